// File: rtl/comma_aligner_8b10b.sv
// Serial-in 8b10b word aligner: hunts K28.5 commas at any bit offset, verifies
// them at a 10-bit spacing, locks symbol phase and emits one aligned symbol per 10 clocks.
module comma_aligner_8b10b #(
  parameter logic [9:0]  COMMA_P     = 10'b0011111010,
  parameter logic [9:0]  COMMA_N     = 10'b1100000101,
  parameter int unsigned LOCK_COUNT  = 3,
  parameter int unsigned UNLOCK_ERRS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       strobin,
  output logic [9:0] sym_data,
  output logic       sym_is_k,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic       locked,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  localparam logic [3:0] LockCnt    = 4'(LOCK_COUNT);
  localparam logic [3:0] UnlockErrs = 4'(UNLOCK_ERRS);

  state_e     state_q, state_d;
  logic [9:0] shift_q;
  logic [3:0] phase_q, phase_d;
  logic [3:0] good_q, good_d;
  logic [3:0] err_q, err_d;
  logic [9:0] symData_q;
  logic       symIsK_q, symValid_q, locked_q, overflow_q;

  logic       comma, boundary, popBad, symErr;
  logic [3:0] onesCnt, goodInc, errInc;

  assign comma    = (shift_q == COMMA_P) || (shift_q == COMMA_N);
  assign boundary = (phase_q == 4'd9);

  always_comb begin
    onesCnt = 4'd0;
    for (int i = 0; i < 10; i++) begin
      onesCnt = onesCnt + {3'b000, shift_q[i]};
    end
  end

  // A valid 8b10b symbol carries 4, 5 or 6 ones; an off-phase comma is also an error.
  assign popBad  = (onesCnt < 4'd4) || (onesCnt > 4'd6);
  assign symErr  = (boundary && popBad) || (comma && !boundary);
  assign goodInc = good_q + 4'd1;
  assign errInc  = (err_q == 4'hF) ? err_q : err_q + 4'd1;

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    phase_d = boundary ? 4'd0 : phase_q + 4'd1;
    unique case (state_q)
      HUNT: begin
        if (comma) begin
          phase_d = 4'd0;
          if (LockCnt == 4'd1) begin
            state_d = LOCKED;
            err_d   = 4'd0;
          end else begin
            state_d = VERIFY;
            good_d  = 4'd1;
          end
        end
      end
      VERIFY: begin
        if (comma && !boundary) begin
          phase_d = 4'd0;
          good_d  = 4'd1;
        end else if (boundary && comma) begin
          good_d = goodInc;
          if (goodInc >= LockCnt) begin
            state_d = LOCKED;
            err_d   = 4'd0;
          end
        end else if (boundary && popBad) begin
          state_d = HUNT;
          good_d  = 4'd0;
        end
      end
      LOCKED: begin
        // Once locked, phase is never moved; stray commas only count as errors.
        if (symErr) begin
          if (errInc >= UnlockErrs) begin
            state_d = HUNT;
            err_d   = 4'd0;
            good_d  = 4'd0;
          end else begin
            err_d = errInc;
          end
        end else if (boundary && comma) begin
          err_d = 4'd0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      shift_q <= 10'd0;
      phase_q <= 4'd0;
      good_q  <= 4'd0;
      err_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      shift_q <= {shift_q[8:0], strobin};
      phase_q <= phase_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  // Output stage: the symbol completed at a locked boundary is presented on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      symData_q  <= 10'd0;
      symIsK_q   <= 1'b0;
      symValid_q <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      locked_q <= (state_d == LOCKED);
      if (boundary && (state_q == LOCKED)) begin
        symData_q  <= shift_q;
        symIsK_q   <= comma;
        symValid_q <= 1'b1;
      end else begin
        symValid_q <= 1'b0;
      end
      if (symValid_q && !sym_ready) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign sym_data  = symData_q;
  assign sym_is_k  = symIsK_q;
  assign sym_valid = symValid_q;
  assign locked    = locked_q;
  assign overflow  = overflow_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_comma_aligner_8b10b.sv
// Bench for comma_aligner_8b10b: directed scenarios plus random symbols, every
// cycle compared against a bit-history reference model that tracks symbol phase arithmetically.
module tb_comma_aligner_8b10b;

  localparam logic [9:0] COMMA_P = 10'b0011111010;
  localparam logic [9:0] COMMA_N = 10'b1100000101;
  localparam logic [9:0] D21     = 10'b1010101010;
  localparam logic [9:0] BAD     = 10'h3FF;
  localparam int LOCK_COUNT  = 3;
  localparam int UNLOCK_ERRS = 4;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic       clk = 1'b0;
  logic       rst_n, strobin, sym_ready, ovf_clr;
  logic [9:0] sym_data;
  logic       sym_is_k, sym_valid, locked, overflow;
  logic [3:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: boundary when (cycle - anchor) is a multiple of 10.
  logic [9:0] mWin;
  int         mCycle, mAnchor, mMode, mGood, mErrs;
  logic [9:0] mData;
  logic       mIsK, mValid, mOvf;

  comma_aligner_8b10b dut (
    .clk(clk), .rst_n(rst_n), .strobin(strobin),
    .sym_data(sym_data), .sym_is_k(sym_is_k), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .locked(locked), .overflow(overflow),
    .ovf_clr(ovf_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mWin = '0; mCycle = 0; mAnchor = -1; mMode = M_HUNT; mGood = 0; mErrs = 0;
    mData = '0; mIsK = 1'b0; mValid = 1'b0; mOvf = 1'b0;
  endtask

  task automatic modelEdge(input logic b);
    logic isComma, bnd, popBad, symErr;
    int   ones;
    ones    = $countones(mWin);
    isComma = (mWin == COMMA_P) || (mWin == COMMA_N);
    bnd     = ((mCycle - mAnchor) % 10) == 0;
    popBad  = (ones < 4) || (ones > 6);
    symErr  = (bnd && popBad) || (isComma && !bnd);
    if (mValid && !sym_ready) mOvf = 1'b1;
    else if (ovf_clr) mOvf = 1'b0;
    if (bnd && mMode == M_LOCKED) begin
      mData = mWin; mIsK = isComma; mValid = 1'b1;
    end else begin
      mValid = 1'b0;
    end
    case (mMode)
      M_HUNT: if (isComma) begin
        mAnchor = mCycle;
        if (LOCK_COUNT == 1) begin mMode = M_LOCKED; mErrs = 0; end
        else begin mMode = M_VERIFY; mGood = 1; end
      end
      M_VERIFY: begin
        if (isComma && !bnd) begin
          mAnchor = mCycle; mGood = 1;
        end else if (bnd && isComma) begin
          mGood++;
          if (mGood >= LOCK_COUNT) begin mMode = M_LOCKED; mErrs = 0; end
        end else if (bnd && popBad) begin
          mMode = M_HUNT; mGood = 0;
        end
      end
      default: begin
        if (symErr) begin
          mErrs++;
          if (mErrs >= UNLOCK_ERRS) begin mMode = M_HUNT; mErrs = 0; mGood = 0; end
        end else if (bnd && isComma) begin
          mErrs = 0;
        end
      end
    endcase
    mWin = {mWin[8:0], b};
    mCycle++;
  endtask

  task automatic checkAll();
    checkOutput("locked",    {9'b0, locked},    {9'b0, (mMode == M_LOCKED)});
    checkOutput("sym_valid", {9'b0, sym_valid}, {9'b0, mValid});
    checkOutput("sym_data",  sym_data,          mData);
    checkOutput("sym_is_k",  {9'b0, sym_is_k},  {9'b0, mIsK});
    checkOutput("err_cnt",   {6'b0, err_cnt},   {6'b0, 4'(mErrs)});
    checkOutput("overflow",  {9'b0, overflow},  {9'b0, mOvf});
  endtask

  task automatic applyStimulus(input logic b);
    strobin = b;
    modelEdge(b);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic sendSym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) applyStimulus(s[i]);
  endtask

  task automatic stepAlt();
    applyStimulus(~mWin[0]);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_data"},   sym_data,          10'd0);
    checkOutput({tag, "_valid"},  {9'b0, sym_valid}, 10'd0);
    checkOutput({tag, "_isk"},    {9'b0, sym_is_k},  10'd0);
    checkOutput({tag, "_locked"}, {9'b0, locked},    10'd0);
    checkOutput({tag, "_ovf"},    {9'b0, overflow},  10'd0);
    checkOutput({tag, "_err"},    {6'b0, err_cnt},   10'd0);
  endtask

  task automatic waitValid();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      stepAlt();
      if (mValid) found = 1'b1;
    end
    checkOutput("waitValid", {9'b0, found}, 10'd1);
  endtask

  initial begin
    logic [9:0] sym;
    rst_n = 1'b1; strobin = 1'b0; sym_ready = 1'b1; ovf_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst");
    modelReset();
    @(posedge clk); #1; rst_n = 1'b1;

    // Lock on three RD- commas after a 3-bit lead-in, then check the first emitted comma.
    for (int i = 0; i < 3; i++) applyStimulus(1'($urandom_range(0, 1)));
    sendSym(COMMA_P);
    sendSym(COMMA_P);
    sendSym(COMMA_P);
    checkOutput("t1_notYet", {9'b0, locked}, 10'd0);
    applyStimulus(COMMA_P[9]);
    checkOutput("t1_locked", {9'b0, locked}, 10'd1);
    for (int i = 8; i >= 0; i--) applyStimulus(COMMA_P[i]);
    applyStimulus(D21[9]);
    checkOutput("t1_kValid", {9'b0, sym_valid}, 10'd1);
    checkOutput("t1_kFlag",  {9'b0, sym_is_k},  10'd1);
    checkOutput("t1_kData",  sym_data,          COMMA_P);
    for (int i = 8; i >= 0; i--) applyStimulus(D21[i]);

    sendSym(D21);
    sendSym(D21);
    checkOutput("t2_data", sym_data,        10'h2AA);
    checkOutput("t2_err",  {6'b0, err_cnt}, 10'd0);

    // Four bad-disparity symbols drop lock.
    sendSym(BAD);
    sendSym(BAD);
    sendSym(BAD);
    applyStimulus(BAD[9]);
    checkOutput("t3_err3", {6'b0, err_cnt}, 10'd3);
    for (int i = 8; i >= 0; i--) applyStimulus(BAD[i]);
    applyStimulus(1'b1);
    checkOutput("t3_unlock", {9'b0, locked}, 10'd0);
    checkOutput("t3_err0",   {6'b0, err_cnt}, 10'd0);

    // Realign: comma, 4-bit slip, then commas at the new phase.
    sendSym(COMMA_P);
    for (int i = 0; i < 4; i++) applyStimulus(1'(i % 2 == 0));
    sendSym(COMMA_P);
    sendSym(COMMA_N);
    checkOutput("t4_notYet", {9'b0, locked}, 10'd0);
    sendSym(COMMA_P);
    applyStimulus(1'b1);
    checkOutput("t4_locked", {9'b0, locked}, 10'd1);

    // Overflow: drop, hold, clear, then set-wins-over-clear.
    waitValid();
    sym_ready = 1'b0;
    stepAlt();
    sym_ready = 1'b1;
    checkOutput("t5_ovfSet", {9'b0, overflow}, 10'd1);
    repeat (3) stepAlt();
    ovf_clr = 1'b1;
    stepAlt();
    ovf_clr = 1'b0;
    checkOutput("t5_ovfClr", {9'b0, overflow}, 10'd0);
    waitValid();
    sym_ready = 1'b0; ovf_clr = 1'b1;
    stepAlt();
    sym_ready = 1'b1; ovf_clr = 1'b0;
    checkOutput("t5_setWins", {9'b0, overflow}, 10'd1);
    ovf_clr = 1'b1;
    stepAlt();
    ovf_clr = 1'b0;

    // Asynchronous reset mid-symbol while locked.
    repeat (5) stepAlt();
    checkOutput("t6_preLocked", {9'b0, locked}, 10'd1);
    #3; rst_n = 1'b0;
    #1;
    checkResetOutputs("t6");
    modelReset();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (30) stepAlt();
    checkOutput("t6_noLock", {9'b0, locked}, 10'd0);

    // Relock, then random symbols with random backpressure and clears.
    sendSym(COMMA_N);
    sendSym(COMMA_P);
    sendSym(COMMA_P);
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 4))
        0:       sym = COMMA_P;
        1:       sym = COMMA_N;
        2:       sym = BAD;
        3:       sym = 10'($urandom);
        default: sym = D21;
      endcase
      for (int i = 9; i >= 0; i--) begin
        sym_ready = ($urandom_range(0, 3) != 0);
        ovf_clr   = ($urandom_range(0, 15) == 0);
        applyStimulus(sym[i]);
      end
    end
    sym_ready = 1'b1; ovf_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
